oflow_score_calc_nch: RTL and testbench
=======================================

Name: oflow_score_calc_nch

Overview:
Parametrised successor of the two-PE score calculator. Compares one current object against a stream of previous-object lines from the MEM buffer, with N_CH lanes per line. For each lane it computes a pipelined weighted score from METRIC_NUM per-feature distance metrics, and keeps a running minimum score and its ID per lane over the whole line stream. Sits between the similarity-metric stage and oflow_score_board, and replaces the fixed min_score_0/min_score_1 outputs with vectors of N_CH lanes.

Parameters:
N_CH, 2, lanes per buffer line
METRIC_NUM, 6, metrics per lane (iou, w, h, color1, color2, dhistory)
METRIC_LEN, 11, unsigned width of each metric
WEIGHT_LEN, 10, unsigned weight width; fixed point with WEIGHT_LEN-1 fraction bits (1.0 = 0x200)
SCORE_LEN, 12, unsigned saturated score width
ID_LEN, 7, object ID width

Ports:
clk  in  1  clock
reset_N  in  1  asynchronous active-low reset
start_score_calc  in  1  pulse: clear minima, latch weights, enter RUN
weights  in  METRIC_NUM*WEIGHT_LEN  weight k at bits [k*WEIGHT_LEN +: WEIGHT_LEN]
line_valid  in  1  a line is presented this cycle
line_ch_en  in  N_CH  per-lane valid (partial last line)
line_last  in  1  qualifies line_valid: final line of the stream
metric_in  in  N_CH*METRIC_NUM*METRIC_LEN  lane c, metric k at index (c*METRIC_NUM+k)
id_in  in  N_CH*ID_LEN  ID per lane
ready_for_line  out  1  line accepted this cycle if line_valid
min_score  out  N_CH*SCORE_LEN  running minimum per lane
min_id  out  N_CH*ID_LEN  ID of min_score
min_valid  out  N_CH  lane has seen at least one enabled entry
done_score_calc  out  1  one-cycle pulse: final minima valid
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_N=0): state=IDLE; min_score = all ones; min_id=0; min_valid=0; done_score_calc=0; busy=0; ready_for_line=0; pipeline valids=0; latched weights=0.
- FSM:
  - IDLE -> RUN on start_score_calc.
  - RUN -> DRAIN on an accepted line with line_last=1.
  - DRAIN -> IDLE on the edge where the last line's compare completes; done_score_calc pulses at that same edge.
- ready_for_line = (state==RUN). Lines with line_valid=1 outside RUN are ignored.
- Start sampling (edge where start_score_calc=1): weights latched, minima reset to the reset values, pipeline valids cleared.
- Start in RUN or DRAIN aborts the stream: in-flight lines discarded, no done pulse, state=RUN.
- Pipeline. Line accepted at edge k:
  - S1 (edge k): per-lane, per-metric products metric*weight, METRIC_LEN+WEIGHT_LEN bits, registered.
  - S2 (edge k+1): products summed at full width, >> (WEIGHT_LEN-1), saturated to 2^SCORE_LEN-1, registered with ID and lane enable.
  - S3 (edge k+2): compare/update of the running minimum.
  - min_* reflect line k from edge k+2. Throughput is one line per cycle.
- Update rule per lane when enabled: if !min_valid or score < min_score, then min_score=score, min_id=id, min_valid=1. Strict less-than, so on a tie the earlier entry is kept.
- Disabled lanes (line_ch_en=0) never update.
- done_score_calc is asserted at edge k_last+2. After done, outputs hold until the next start or reset.

Decomposition:
- Package oflow_score_calc_pkg: default length localparams, state enum (IDLE, RUN, DRAIN), saturate function.
- Sub-module oflow_score_lane: S1–S3 datapath plus minimum register for one lane, instantiated N_CH times by a generate loop.
- Top level holds the FSM, weight latch, valid/last shift chain, and done generation.

Test Plan:
- Reset: hold reset_N=0 mid-run -> all outputs at reset values immediately; after release, busy=0, min_score=0xFFF, min_valid=0.
- Single line: weights {0x200,0,0,0,0,0}; lane0 m0=40 id12; lane1 m0=25 id14; line_last=1 -> at edge k+2: min_score={25,40}, min_id={14,12}, min_valid=2'b11, done pulses once.
- Multi-line tie: lane0 scores 30 (id5), 30 (id9), 50 (id3), one per cycle back-to-back -> final min_score0=30, min_id0=5; done pulses exactly 2 edges after the third line.
- Saturation/arithmetic: all metrics 2047, all weights 0x3FF -> min_score=0xFFF. Weights 0x100 on m1 only, m1=100 -> score 50.
- Partial line: line_ch_en=2'b01 on the only line -> min_valid=2'b01, min_score1=0xFFF, min_id1=0.
- Abort: start, two lines, then start again with line_last pending in the pipeline -> no done pulse; minima cleared; a new one-line stream completes normally.

Source files
------------

// File: rtl/oflow_score_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oflow_score_calc_pkg
// Description : Shared lengths, FSM state encoding and score saturation helper
//               for the N-lane score calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package oflow_score_calc_pkg;

  // Default datapath lengths
  localparam int c_n_ch_def       = 2;
  localparam int c_metric_num_def = 6;
  localparam int c_metric_len_def = 11;
  localparam int c_weight_len_def = 10;
  localparam int c_score_len_def  = 12;
  localparam int c_id_len_def     = 7;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clamp an unsigned value to the largest number representable in 'width' bits
  function automatic logic [63:0] saturate(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oflow_score_lane.sv
`default_nettype none
// ============================================================================
// Module      : oflow_score_lane
// Description : One lane of the score calculator: weighted products (S1),
//               shifted/saturated sum (S2) and running-minimum update (S3).
// Revision    : 1.0 - initial release
// ============================================================================
module oflow_score_lane
  import oflow_score_calc_pkg::*;
#(
  parameter int METRIC_NUM = c_metric_num_def,
  parameter int METRIC_LEN = c_metric_len_def,
  parameter int WEIGHT_LEN = c_weight_len_def,
  parameter int SCORE_LEN  = c_score_len_def,
  parameter int ID_LEN     = c_id_len_def
) (
  input  logic                             clk,
  input  logic                             reset_N,
  input  logic                             clear,
  input  logic                             accept,
  input  logic                             s1_valid,
  input  logic                             s2_valid,
  input  logic [METRIC_NUM*METRIC_LEN-1:0] metric,
  input  logic [METRIC_NUM*WEIGHT_LEN-1:0] weights,
  input  logic [ID_LEN-1:0]                id_in,
  input  logic                             ch_en,
  output logic [SCORE_LEN-1:0]             min_score,
  output logic [ID_LEN-1:0]                min_id,
  output logic                             min_valid
);

  localparam int c_prod_len = METRIC_LEN + WEIGHT_LEN;
  // Headroom for summing METRIC_NUM full-width products without overflow
  localparam int c_sum_len  = c_prod_len + $clog2(METRIC_NUM + 1);

  logic [METRIC_NUM-1:0][c_prod_len-1:0] w_prod;
  logic [METRIC_NUM-1:0][c_prod_len-1:0] r_prod;
  logic [ID_LEN-1:0]                     r_id1;
  logic                                  r_en1;

  logic [c_sum_len-1:0]                  w_sum;
  logic [c_sum_len-1:0]                  w_shift;
  logic [SCORE_LEN-1:0]                  w_score;
  logic [SCORE_LEN-1:0]                  r_score;
  logic [ID_LEN-1:0]                     r_id2;
  logic                                  r_en2;

  logic [SCORE_LEN-1:0]                  r_min_score;
  logic [ID_LEN-1:0]                     r_min_id;
  logic                                  r_min_valid;

  // Per-metric unsigned products at full width
  always_comb begin
    w_prod = '0;
    for (int k = 0; k < METRIC_NUM; k++) begin
      w_prod[k] = c_prod_len'(metric[k*METRIC_LEN +: METRIC_LEN])
                * c_prod_len'(weights[k*WEIGHT_LEN +: WEIGHT_LEN]);
    end
  end

  // S1: register products together with the entry ID and lane enable
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_prod <= '0;
      r_id1  <= '0;
      r_en1  <= 1'b0;
    end else if (accept) begin
      r_prod <= w_prod;
      r_id1  <= id_in;
      r_en1  <= ch_en;
    end
  end

  // Sum products, drop the weight fraction bits, then clamp to the score range
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < METRIC_NUM; k++) begin
      w_sum = w_sum + c_sum_len'(r_prod[k]);
    end
    w_shift = w_sum >> (WEIGHT_LEN - 1);
    w_score = SCORE_LEN'(saturate(64'(w_shift), SCORE_LEN));
  end

  // S2: register the final score with its ID and enable
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_score <= '0;
      r_id2   <= '0;
      r_en2   <= 1'b0;
    end else if (s1_valid) begin
      r_score <= w_score;
      r_id2   <= r_id1;
      r_en2   <= r_en1;
    end
  end

  // S3: running minimum; strict less-than keeps the earliest entry on ties
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_min_score <= '1;
      r_min_id    <= '0;
      r_min_valid <= 1'b0;
    end else if (clear) begin
      r_min_score <= '1;
      r_min_id    <= '0;
      r_min_valid <= 1'b0;
    end else if (s2_valid && r_en2 && (!r_min_valid || (r_score < r_min_score))) begin
      r_min_score <= r_score;
      r_min_id    <= r_id2;
      r_min_valid <= 1'b1;
    end
  end

  assign min_score = r_min_score;
  assign min_id    = r_min_id;
  assign min_valid = r_min_valid;

endmodule
`default_nettype wire

// File: rtl/oflow_score_calc_nch.sv
`default_nettype none
// ============================================================================
// Module      : oflow_score_calc_nch
// Description : N-lane score calculator. Streams previous-object lines, keeps
//               a per-lane minimum score/ID and pulses done when the final
//               line has been compared.
// Revision    : 1.0 - initial release
// ============================================================================
module oflow_score_calc_nch
  import oflow_score_calc_pkg::*;
#(
  parameter int N_CH       = c_n_ch_def,
  parameter int METRIC_NUM = c_metric_num_def,
  parameter int METRIC_LEN = c_metric_len_def,
  parameter int WEIGHT_LEN = c_weight_len_def,
  parameter int SCORE_LEN  = c_score_len_def,
  parameter int ID_LEN     = c_id_len_def
) (
  input  logic                                  clk,
  input  logic                                  reset_N,
  input  logic                                  start_score_calc,
  input  logic [METRIC_NUM*WEIGHT_LEN-1:0]      weights,
  input  logic                                  line_valid,
  input  logic [N_CH-1:0]                       line_ch_en,
  input  logic                                  line_last,
  input  logic [N_CH*METRIC_NUM*METRIC_LEN-1:0] metric_in,
  input  logic [N_CH*ID_LEN-1:0]                id_in,
  output logic                                  ready_for_line,
  output logic [N_CH*SCORE_LEN-1:0]             min_score,
  output logic [N_CH*ID_LEN-1:0]                min_id,
  output logic [N_CH-1:0]                       min_valid,
  output logic                                  done_score_calc,
  output logic                                  busy
);

  localparam int c_lane_metric_w = METRIC_NUM * METRIC_LEN;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [METRIC_NUM*WEIGHT_LEN-1:0] r_weights;
  logic                            w_accept;
  logic                            w_done_set;
  logic                            r_v1;
  logic                            r_last1;
  logic                            r_v2;
  logic                            r_last2;
  logic                            r_done;

  // A start on the same edge aborts, so a coincident line is not taken
  assign w_accept   = line_valid && (r_state == RUN) && !start_score_calc;
  // The last line leaves S2 on this edge, so its compare completes here
  assign w_done_set = r_v2 && r_last2 && !start_score_calc;

  // State register
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start always (re)enters RUN
  always_comb begin
    w_state_next = r_state;
    if (start_score_calc) begin
      w_state_next = RUN;
    end else begin
      case (r_state)
        IDLE:    w_state_next = IDLE;
        RUN:     if (w_accept && line_last) w_state_next = DRAIN;
        DRAIN:   if (w_done_set) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Weights are captured once per stream at start
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_weights <= '0;
    end else if (start_score_calc) begin
      r_weights <= weights;
    end
  end

  // Valid/last tracking alongside S1 and S2; start flushes in-flight lines
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
    end else if (start_score_calc) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
    end else begin
      r_v1    <= w_accept;
      r_last1 <= w_accept && line_last;
      r_v2    <= r_v1;
      r_last2 <= r_last1;
    end
  end

  // One-cycle done pulse coincident with the final minimum update
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_set;
    end
  end

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_lane
      oflow_score_lane #(
        .METRIC_NUM (METRIC_NUM),
        .METRIC_LEN (METRIC_LEN),
        .WEIGHT_LEN (WEIGHT_LEN),
        .SCORE_LEN  (SCORE_LEN),
        .ID_LEN     (ID_LEN)
      ) u_lane (
        .clk       (clk),
        .reset_N   (reset_N),
        .clear     (start_score_calc),
        .accept    (w_accept),
        .s1_valid  (r_v1),
        .s2_valid  (r_v2),
        .metric    (metric_in[c*c_lane_metric_w +: c_lane_metric_w]),
        .weights   (r_weights),
        .id_in     (id_in[c*ID_LEN +: ID_LEN]),
        .ch_en     (line_ch_en[c]),
        .min_score (min_score[c*SCORE_LEN +: SCORE_LEN]),
        .min_id    (min_id[c*ID_LEN +: ID_LEN]),
        .min_valid (min_valid[c])
      );
    end
  endgenerate

  assign ready_for_line  = (r_state == RUN);
  assign busy            = (r_state != IDLE);
  assign done_score_calc = r_done;

endmodule
`default_nettype wire

// File: tb/tb_oflow_score_calc_nch.sv
`default_nettype none
// ============================================================================
// Module      : tb_oflow_score_calc_nch
// Description : Scoreboard bench for oflow_score_calc_nch. Directed streams
//               push expected minima; a monitor compares them on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oflow_score_calc_nch;

  localparam int N_CH = 2;
  localparam int MN   = 6;
  localparam int ML   = 11;
  localparam int WL   = 10;
  localparam int SL   = 12;
  localparam int IL   = 7;

  logic                  clk = 1'b0;
  logic                  reset_N;
  logic                  start_score_calc;
  logic [MN*WL-1:0]      weights;
  logic                  line_valid;
  logic [N_CH-1:0]       line_ch_en;
  logic                  line_last;
  logic [N_CH*MN*ML-1:0] metric_in;
  logic [N_CH*IL-1:0]    id_in;
  logic                  ready_for_line;
  logic [N_CH*SL-1:0]    min_score;
  logic [N_CH*IL-1:0]    min_id;
  logic [N_CH-1:0]       min_valid;
  logic                  done_score_calc;
  logic                  busy;

  typedef struct {
    logic [N_CH*SL-1:0] score;
    logic [N_CH*IL-1:0] id;
    logic [N_CH-1:0]    valid;
    int                 done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  oflow_score_calc_nch #(
    .N_CH(N_CH), .METRIC_NUM(MN), .METRIC_LEN(ML),
    .WEIGHT_LEN(WL), .SCORE_LEN(SL), .ID_LEN(IL)
  ) dut (
    .clk              (clk),
    .reset_N          (reset_N),
    .start_score_calc (start_score_calc),
    .weights          (weights),
    .line_valid       (line_valid),
    .line_ch_en       (line_ch_en),
    .line_last        (line_last),
    .metric_in        (metric_in),
    .id_in            (id_in),
    .ready_for_line   (ready_for_line),
    .min_score        (min_score),
    .min_id           (min_id),
    .min_valid        (min_valid),
    .done_score_calc  (done_score_calc),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Edge counter used to time the done pulse
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected stream result
  always @(negedge clk) begin
    if (reset_N === 1'b1 && done_score_calc === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: actual=1 required=0 at edge %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("min_score", 64'(min_score), 64'(e.score));
        check("min_id",    64'(min_id),    64'(e.id));
        check("min_valid", 64'(min_valid), 64'(e.valid));
        check("done_edge", 64'(cyc),       64'(e.done_cyc));
        check("busy_at_done", 64'(busy),   64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [MN-1:0][WL-1:0] w);
    weights          = w;
    start_score_calc = 1'b1;
    tick();
    start_score_calc = 1'b0;
  endtask

  // Called just before the last line is driven: done lands 3 edges later
  task automatic expect_result(input logic [N_CH*SL-1:0] s, input logic [N_CH*IL-1:0] i,
                               input logic [N_CH-1:0] v);
    exp_t e;
    e.score    = s;
    e.id       = i;
    e.valid    = v;
    e.done_cyc = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic send_line(input logic [MN-1:0][ML-1:0] l0, input logic [MN-1:0][ML-1:0] l1,
                           input logic [IL-1:0] id0, input logic [IL-1:0] id1,
                           input logic [N_CH-1:0] en, input logic last);
    metric_in  = {l1, l0};
    id_in      = {id1, id0};
    line_ch_en = en;
    line_last  = last;
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    line_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),            64'd0);
    check({tag, "_ready"},     64'(ready_for_line),  64'd0);
    check({tag, "_min_score"}, 64'(min_score),       64'hFFFFFF);
    check({tag, "_min_id"},    64'(min_id),          64'd0);
    check({tag, "_min_valid"}, 64'(min_valid),       64'd0);
    check({tag, "_done"},      64'(done_score_calc), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [MN-1:0][WL-1:0] w_unit;
    logic [MN-1:0][WL-1:0] w_full;
    logic [MN-1:0][WL-1:0] w_half1;
    logic [MN-1:0][ML-1:0] a;
    logic [MN-1:0][ML-1:0] b;

    reset_N          = 1'b0;
    start_score_calc = 1'b0;
    weights          = '0;
    line_valid       = 1'b0;
    line_ch_en       = '0;
    line_last        = 1'b0;
    metric_in        = '0;
    id_in            = '0;

    w_unit     = '0;
    w_unit[0]  = 10'h200;
    w_full     = {MN{10'h3FF}};
    w_half1    = '0;
    w_half1[1] = 10'h100;

    // Reset state, during and after reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    reset_N = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // Single line: 40 and 25 with unit weight on metric 0
    do_start(w_unit);
    check("ready_in_run", 64'(ready_for_line), 64'd1);
    a = '0; a[0] = 11'd40;
    b = '0; b[0] = 11'd25;
    expect_result({12'd25, 12'd40}, {7'd14, 7'd12}, 2'b11);
    send_line(a, b, 7'd12, 7'd14, 2'b11, 1'b1);
    wait_drain();

    // Back-to-back lines with a tie on lane 0 (first entry wins)
    do_start(w_unit);
    a = '0; a[0] = 11'd30;  b = '0; b[0] = 11'd100;
    send_line(a, b, 7'd5, 7'd1, 2'b11, 1'b0);
    a = '0; a[0] = 11'd30;  b = '0; b[0] = 11'd7;
    send_line(a, b, 7'd9, 7'd2, 2'b11, 1'b0);
    a = '0; a[0] = 11'd50;  b = '0; b[0] = 11'd8;
    expect_result({12'd7, 12'd30}, {7'd2, 7'd5}, 2'b11);
    send_line(a, b, 7'd3, 7'd3, 2'b11, 1'b1);
    wait_drain();

    // Saturation: every metric and weight at maximum
    do_start(w_full);
    a = {MN{11'h7FF}};
    b = {MN{11'h7FF}};
    expect_result({12'hFFF, 12'hFFF}, {7'd2, 7'd1}, 2'b11);
    send_line(a, b, 7'd1, 7'd2, 2'b11, 1'b1);
    wait_drain();

    // Half weight on metric 1 only: 100 -> 50, 7 -> 3 (fraction dropped)
    do_start(w_half1);
    a = '0; a[1] = 11'd100;
    b = '0; b[0] = 11'd500; b[1] = 11'd7;
    expect_result({12'd3, 12'd50}, {7'd21, 7'd20}, 2'b11);
    send_line(a, b, 7'd20, 7'd21, 2'b11, 1'b1);
    wait_drain();

    // Partial line: lane 1 disabled keeps its reset values
    do_start(w_unit);
    a = '0; a[0] = 11'd60;
    b = '0; b[0] = 11'd10;
    expect_result({12'hFFF, 12'd60}, {7'd0, 7'd33}, 2'b01);
    send_line(a, b, 7'd33, 7'd44, 2'b01, 1'b1);
    wait_drain();

    // Abort: restart while the last line is still in the pipeline
    do_start(w_unit);
    a = '0; a[0] = 11'd10;  b = '0; b[0] = 11'd20;
    send_line(a, b, 7'd1, 7'd2, 2'b11, 1'b0);
    a = '0; a[0] = 11'd5;   b = '0; b[0] = 11'd6;
    send_line(a, b, 7'd3, 7'd4, 2'b11, 1'b1);
    do_start(w_unit);
    check("abort_busy",      64'(busy),           64'd1);
    check("abort_ready",     64'(ready_for_line), 64'd1);
    check("abort_min_valid", 64'(min_valid),      64'd0);
    check("abort_min_score", 64'(min_score),      64'hFFFFFF);
    repeat (4) tick();
    check("abort_flushed_valid", 64'(min_valid),  64'd0);
    a = '0; a[0] = 11'd77;  b = '0; b[0] = 11'd88;
    expect_result({12'd88, 12'd77}, {7'd10, 7'd9}, 2'b11);
    send_line(a, b, 7'd9, 7'd10, 2'b11, 1'b1);
    wait_drain();

    // Asynchronous reset in the middle of a stream
    do_start(w_unit);
    a = '0; a[0] = 11'd15;  b = '0; b[0] = 11'd16;
    send_line(a, b, 7'd6, 7'd7, 2'b11, 1'b0);
    repeat (3) tick();
    check("midrun_min_score", 64'(min_score), {40'd0, 12'd16, 12'd15});
    check("midrun_min_valid", 64'(min_valid), 64'd3);
    #2;
    reset_N = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    reset_N = 1'b1;
    tick();
    check("after_reset_busy",      64'(busy),      64'd0);
    check("after_reset_min_score", 64'(min_score), 64'hFFFFFF);
    check("after_reset_min_valid", 64'(min_valid), 64'd0);

    repeat (3) tick();
    check("final_queue_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
